// File: rtl/problema1_oci_dct_pkg.sv
// Shared constants and types for the OCI data-trace (DCT) packer.
// Fragment/frame geometry, FSM state encoding and the frame bundle.
package problema1_oci_dct_pkg;

  localparam int FRAG_W = 2;
  localparam int NFRAG  = 15;
  localparam int BUF_W  = FRAG_W * NFRAG;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } dct_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [BUF_W-1:0] data;
  } dct_frame_t;

endpackage

// File: rtl/problema1_oci_dct_frame_slot.sv
// Single-entry valid/ready holding register for one packed frame.
// Ports: clk, reset, load/din (write), ready (consume), valid/dout.
module problema1_oci_dct_frame_slot
  import problema1_oci_dct_pkg::*;
#(
  parameter int W = BUF_W + CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  // load wins over consume: the caller only loads when the slot
  // is empty or being consumed on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/problema1_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace fragments into 30-bit frames with flush/drain.
// Ports: frag_* in, dct_* out (valid/ready), flush, test_ending/has_ended.
module problema1_nios2_qsys_0_oci_dct_packer
  import problema1_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              frag_valid,
  input  logic [FRAG_W-1:0] frag_data,
  output logic              frag_ready,
  input  logic              flush,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              dct_valid,
  input  logic              dct_ready,
  input  logic              test_ending,
  output logic              test_has_ended
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NFRAG);

  dct_state_e       state;
  logic [BUF_W-1:0] acc;
  logic [BUF_W-1:0] acc_n;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             flush_pend;
  logic             pend_n;
  logic             accept;
  logic             close;
  logic             xfer;
  logic [BUF_W-1:0] frag_ext;
  dct_frame_t       frame_in;
  dct_frame_t       frame_out;

  assign frag_ready = (state == ST_RUN) && (acc_cnt < FULL);
  assign accept     = frag_valid && frag_ready;
  assign close      = (acc_cnt == FULL) ||
                      ((flush_pend || state == ST_DRAIN) &&
                       (acc_cnt != '0));
  assign xfer       = close && (!dct_valid || dct_ready);
  assign frag_ext   = BUF_W'(frag_data);

  // Transfer empties the accumulator first, so a fragment taken on
  // the same edge lands at slot 0 of the following frame.
  always_comb begin
    acc_n = acc;
    cnt_n = acc_cnt;
    if (xfer) begin
      acc_n = '0;
      cnt_n = '0;
    end
    if (accept) begin
      acc_n = acc_n | (frag_ext << (FRAG_W * int'(cnt_n)));
      cnt_n = cnt_n + CNT_W'(1);
    end
  end

  // A pending flush never survives into an empty accumulator.
  always_comb begin
    pend_n = xfer ? flush : (flush_pend | flush);
    if (cnt_n == '0) begin
      pend_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      acc        <= acc_n;
      acc_cnt    <= cnt_n;
      flush_pend <= pend_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_RUN;
      test_has_ended <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (test_ending) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (acc_cnt == '0 && !dct_valid) begin
            state          <= ST_DONE;
            test_has_ended <= 1'b1;
          end
        end
        ST_DONE: begin
          test_has_ended <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign frame_in.cnt  = acc_cnt;
  assign frame_in.data = acc;

  problema1_oci_dct_frame_slot #(
    .W (BUF_W + CNT_W)
  ) u_slot (
    .clk   (clk),
    .reset (reset),
    .load  (xfer),
    .din   (frame_in),
    .ready (dct_ready),
    .valid (dct_valid),
    .dout  (frame_out)
  );

  assign dct_buffer = frame_out.data;
  assign dct_count  = frame_out.cnt;

endmodule

// File: tb/tb_problema1_nios2_qsys_0_oci_dct_packer.sv
// Testbench for the DCT packer: directed sequence with random data.
// Expected frames come from a fragment queue packed arithmetically.
module tb_problema1_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frag_valid;
  logic [1:0]  frag_data;
  logic        frag_ready;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_ending;
  logic        test_has_ended;

  int total  = 0;
  int passed = 0;
  int fq[$];

  problema1_nios2_qsys_0_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .frag_valid     (frag_valid),
    .frag_data      (frag_data),
    .frag_ready     (frag_ready),
    .flush          (flush),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame value = sum of fragment k times 4^k.
  function automatic logic [31:0] pack(input int start, input int n);
    longint v = 0;
    longint w = 1;
    for (int k = 0; k < n; k++) begin
      v += longint'(fq[start + k]) * w;
      w *= 4;
    end
    return 32'(v);
  endfunction

  function automatic void drop(input int n);
    for (int k = 0; k < n; k++) begin
      void'(fq.pop_front());
    end
  endfunction

  task automatic send(input logic [1:0] d);
    int b = 0;
    while (!frag_ready && b < 50) begin
      step();
      b++;
    end
    chk("frag_ready_wait", 32'(frag_ready), 32'd1);
    frag_valid = 1'b1;
    frag_data  = d;
    step();
    frag_valid = 1'b0;
    fq.push_back(int'(d));
  endtask

  task automatic rsend();
    logic [1:0] d;
    d = 2'($urandom_range(0, 3));
    send(d);
  endtask

  initial begin
    logic [31:0] exp;
    int b;
    reset       = 1'b1;
    frag_valid  = 1'b0;
    frag_data   = 2'd0;
    flush       = 1'b0;
    dct_ready   = 1'b1;
    test_ending = 1'b0;
    #12;
    chk("rst_buffer", 32'(dct_buffer), 32'd0);
    chk("rst_count", 32'(dct_count), 32'd0);
    chk("rst_valid", 32'(dct_valid), 32'd0);
    chk("rst_ended", 32'(test_has_ended), 32'd0);
    chk("rst_frag_ready", 32'(frag_ready), 32'd1);
    step();
    reset = 1'b0;
    step();

    for (int k = 0; k < 15; k++) send(2'(k % 4));
    chk("full_not_yet", 32'(dct_valid), 32'd0);
    step();
    exp = pack(0, 15);
    drop(15);
    chk("full_valid", 32'(dct_valid), 32'd1);
    chk("full_buffer", 32'(dct_buffer), exp);
    chk("full_count", 32'(dct_count), 32'd15);
    step();
    chk("full_consumed", 32'(dct_valid), 32'd0);

    for (int k = 0; k < 15; k++) rsend();
    step();
    exp = pack(0, 15);
    drop(15);
    chk("rand_valid", 32'(dct_valid), 32'd1);
    chk("rand_buffer", 32'(dct_buffer), exp);
    step();

    send(2'd1);
    send(2'd2);
    send(2'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_latency", 32'(dct_valid), 32'd0);
    step();
    exp = pack(0, 3);
    drop(3);
    chk("flush_valid", 32'(dct_valid), 32'd1);
    chk("flush_buffer", 32'(dct_buffer), exp);
    chk("flush_count", 32'(dct_count), 32'd3);
    step();
    chk("flush_consumed", 32'(dct_valid), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("empty_flush", 32'(dct_valid), 32'd0);
    end

    dct_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rsend();
      if (i == 20) begin
        chk("hold_mid_buffer", 32'(dct_buffer), pack(0, 15));
      end
    end
    chk("stall_frag_ready", 32'(frag_ready), 32'd0);
    chk("hold_valid", 32'(dct_valid), 32'd1);
    chk("hold_buffer", 32'(dct_buffer), pack(0, 15));
    chk("hold_count", 32'(dct_count), 32'd15);
    repeat (3) step();
    chk("hold_late_buffer", 32'(dct_buffer), pack(0, 15));
    dct_ready = 1'b1;
    step();
    chk("b2b_valid", 32'(dct_valid), 32'd1);
    chk("b2b_buffer", 32'(dct_buffer), pack(15, 15));
    chk("b2b_count", 32'(dct_count), 32'd15);
    step();
    chk("b2b_drained", 32'(dct_valid), 32'd0);
    drop(30);

    dct_ready = 1'b0;
    for (int k = 0; k < 5; k++) rsend();
    test_ending = 1'b1;
    step();
    chk("drain_frag_ready", 32'(frag_ready), 32'd0);
    step();
    chk("drain_valid", 32'(dct_valid), 32'd1);
    chk("drain_count", 32'(dct_count), 32'd5);
    chk("drain_buffer", 32'(dct_buffer), pack(0, 5));
    chk("drain_not_ended", 32'(test_has_ended), 32'd0);
    drop(5);
    dct_ready   = 1'b1;
    test_ending = 1'b0;
    b = 0;
    while (!test_has_ended && b < 10) begin
      step();
      b++;
    end
    chk("ended", 32'(test_has_ended), 32'd1);
    chk("ended_valid", 32'(dct_valid), 32'd0);
    repeat (3) step();
    chk("ended_sticky", 32'(test_has_ended), 32'd1);
    chk("ended_frag_ready", 32'(frag_ready), 32'd0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("rerst_ended", 32'(test_has_ended), 32'd0);
    dct_ready = 1'b0;
    for (int k = 0; k < 22; k++) rsend();
    chk("pre_rst_valid", 32'(dct_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_buffer", 32'(dct_buffer), 32'd0);
    chk("async_count", 32'(dct_count), 32'd0);
    chk("async_valid", 32'(dct_valid), 32'd0);
    chk("async_frag_ready", 32'(frag_ready), 32'd1);
    fq.delete();
    step();
    reset     = 1'b0;
    dct_ready = 1'b1;
    for (int k = 0; k < 15; k++) rsend();
    step();
    chk("clean_valid", 32'(dct_valid), 32'd1);
    chk("clean_buffer", 32'(dct_buffer), pack(0, 15));
    chk("clean_count", 32'(dct_count), 32'd15);
    drop(15);
    step();

    for (int k = 0; k < 3; k++) rsend();
    flush = 1'b1;
    step();
    flush = 1'b0;
    rsend();
    chk("xf_valid", 32'(dct_valid), 32'd1);
    chk("xf_count", 32'(dct_count), 32'd3);
    chk("xf_buffer", 32'(dct_buffer), pack(0, 3));
    drop(3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("xf_next_valid", 32'(dct_valid), 32'd1);
    chk("xf_next_count", 32'(dct_count), 32'd1);
    chk("xf_next_buffer", 32'(dct_buffer), pack(0, 1));
    drop(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
